// File: rtl/bcd_calc_ctrl.sv
// Keypad sequencer for a two-digit BCD adder/subtractor: gathers operands and
// an operator, drives the adder from registers, captures its result and drives the display.
module bcd_calc_ctrl #(
  parameter int EVAL_CYCLES = 1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] key_code,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_sub,
  input  logic [7:0] res_in,
  output logic [7:0] disp,
  output logic       done
);

  localparam int            CW   = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(EVAL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_ENTER_A,
    S_ENTER_B,
    S_EVAL,
    S_RESULT
  } state_t;

  state_t          r_state;
  logic [7:0]      r_a;
  logic [7:0]      r_b;
  logic            r_sub;
  logic [7:0]      r_res;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_disp_hold;
  logic            r_done;

  state_t          w_state_nxt;
  logic [7:0]      w_a_nxt;
  logic [7:0]      w_b_nxt;
  logic            w_sub_nxt;
  logic [7:0]      w_res_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_done_nxt;
  logic [7:0]      w_disp;

  logic            w_accept;
  logic            w_is_digit;
  logic            w_is_op;
  logic            w_is_eq;
  logic            w_is_clr;

  assign key_ready  = (r_state != S_EVAL);
  assign w_accept   = key_valid && key_ready;
  assign w_is_digit = (key_code <= 4'd9);
  assign w_is_op    = (key_code == 4'd10) || (key_code == 4'd11);
  assign w_is_eq    = (key_code == 4'd12);
  assign w_is_clr   = (key_code == 4'd13);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_sub_nxt   = r_sub;
    w_res_nxt   = r_res;
    w_cnt_nxt   = '0;
    w_done_nxt  = 1'b0;

    unique case (r_state)
      S_ENTER_A: begin
        if (w_accept) begin
          if (w_is_digit) begin
            w_a_nxt = {r_a[3:0], key_code};
          end else if (w_is_op) begin
            w_sub_nxt   = key_code[0];
            w_b_nxt     = 8'h00;
            w_state_nxt = S_ENTER_B;
          end
        end
      end

      S_ENTER_B: begin
        if (w_accept) begin
          if (w_is_digit) begin
            w_b_nxt = {r_b[3:0], key_code};
          end else if (w_is_op) begin
            w_sub_nxt = key_code[0];
          end else if (w_is_eq) begin
            w_state_nxt = S_EVAL;
          end
        end
      end

      S_EVAL: begin
        if (r_cnt == LAST) begin
          w_res_nxt   = res_in;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_RESULT;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      S_RESULT: begin
        if (w_accept) begin
          if (w_is_digit) begin
            w_a_nxt     = {4'h0, key_code};
            w_b_nxt     = 8'h00;
            w_state_nxt = S_ENTER_A;
          end else if (w_is_op) begin
            w_a_nxt     = r_res;
            w_sub_nxt   = key_code[0];
            w_b_nxt     = 8'h00;
            w_state_nxt = S_ENTER_B;
          end else if (w_is_eq) begin
            // Repeat-equals: previous result becomes A, last B and operator reused.
            w_a_nxt     = r_res;
            w_state_nxt = S_EVAL;
          end
        end
      end

      default: w_state_nxt = S_ENTER_A;
    endcase

    // Clear behaves like reset; keys are never accepted in EVAL so it cannot abort one.
    if (w_accept && w_is_clr) begin
      w_state_nxt = S_ENTER_A;
      w_a_nxt     = 8'h00;
      w_b_nxt     = 8'h00;
      w_sub_nxt   = 1'b0;
      w_res_nxt   = 8'h00;
      w_cnt_nxt   = '0;
      w_done_nxt  = 1'b0;
    end
  end

  always_comb begin
    w_disp = r_disp_hold;
    unique case (r_state)
      S_ENTER_A: w_disp = r_a;
      S_ENTER_B: w_disp = r_b;
      S_RESULT:  w_disp = r_res;
      default:   w_disp = r_disp_hold;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= S_ENTER_A;
      r_a         <= 8'h00;
      r_b         <= 8'h00;
      r_sub       <= 1'b0;
      r_res       <= 8'h00;
      r_cnt       <= '0;
      r_disp_hold <= 8'h00;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_sub       <= w_sub_nxt;
      r_res       <= w_res_nxt;
      r_cnt       <= w_cnt_nxt;
      r_disp_hold <= w_disp;
      r_done      <= w_done_nxt;
    end
  end

  assign add_a   = r_a;
  assign add_b   = r_b;
  assign add_sub = r_sub;
  assign disp    = w_disp;
  assign done    = r_done;

endmodule
